mo_line_buffer_pp: RTL and testbench
====================================

Name: mo_line_buffer_pp

Overview:
Parametrised ping-pong motion-object horizontal line buffer. It is the successor to the fixed two-bank 2149-based buffer, with configurable line length and pixel width. It adds a reset-time clear pass, first-written-wins priority, collision reporting and clear-behind-read. The sprite renderer writes pixels into the write bank while the video path scans the read bank; the banks swap at each line_start.

Parameters:
LINE_LEN, 512, pixels per line; address width ADDR_W = $clog2(LINE_LEN).
PIX_W, 8, stored pixel width (MPX equivalent).
IDX_W, 4, low colour-index bits; a pixel is transparent when pix[IDX_W-1:0] is all ones.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
line_start  in  1  one-cycle pulse: swap banks, restart read scan.
wr_load  in  1  load write x counter from wr_x.
wr_x  in  ADDR_W  horizontal start position of the object.
wr_pix_valid  in  1  write wr_pix at current x, then x+1.
wr_pix  in  PIX_W  pixel from the object shifter.
rd_en  in  1  advance read scan.
rd_pix  out  PIX_W  pixel read from the read bank.
rd_valid  out  1  rd_pix is valid.
bank_sel  out  1  current write bank (0=A, 1=B); read bank is ~bank_sel.
ready  out  1  clear pass done; buffer usable.
collision  out  1  sticky: an opaque write hit an opaque location this line.
wr_drop  out  1  one-cycle pulse: write discarded.

Behaviour:
- Reset: rd_pix=all ones, rd_valid=0, bank_sel=0, ready=0, collision=0, wr_drop=0, both counters 0, state INIT_CLR.
- Reset mid-operation returns to INIT_CLR from any state; memory contents are not trusted.
- Storage: two LINE_LEN x PIX_W banks; transparent fill value is all ones.
- State INIT_CLR: one address per cycle, same address in both banks, writes all ones. Takes LINE_LEN cycles, then IDLE with ready=1. All inputs are ignored and wr_drop stays 0.
- State IDLE: accepts writes; rd_en is ignored. line_start -> SCAN.
- State SCAN: identical to IDLE, except rd_en is honoured. Read counter reaching LINE_LEN-1 with rd_en -> IDLE. line_start in SCAN restarts the scan and stays in SCAN.
- line_start in IDLE/SCAN:
  - toggles bank_sel;
  - sets read counter to 0;
  - clears collision;
  - write x counter is unchanged.
- Read: rd_en in SCAN reads read-bank[rd_cnt].
  - Latency 1: rd_pix/rd_valid are registered and appear the next cycle.
  - In the same cycle, the location is overwritten with all ones (clear-behind).
  - rd_cnt increments and saturates at LINE_LEN-1; no re-read after the last pixel.
  - rd_valid=0 in any cycle with no read issued the previous cycle.
- Write: wr_load sets wx=wr_x. wr_pix_valid:
  - transparent wr_pix: no store;
  - opaque wr_pix, location transparent: store;
  - opaque wr_pix, location opaque: no store, collision=1 (first-written wins).
  - wx increments for every wr_pix_valid (transparent included), wrapping modulo LINE_LEN; LINE_LEN need not be a power of 2.
- Read-modify-write of the write bank completes within the cycle (combinational read of the write bank, registered write).
- wr_load and wr_pix_valid in the same cycle: the pixel is written at wr_x and wx becomes wr_x+1.
- line_start and wr_pix_valid in the same cycle: the write is discarded, wr_drop=1; wr_load in that cycle still takes effect.
- Writes and reads never target the same bank, so there is no address conflict.

Optional Feature:
Macro MO_LINE_BUF_HFLIP_EN adds input wr_flip (1 bit), sampled with wr_load.
- Defined: if the sampled wr_flip=1, wx decrements per wr_pix_valid, wrapping from 0 to LINE_LEN-1, and the wr_load+wr_pix_valid cycle leaves wx=wr_x-1. wr_flip=0 behaves as the base design.
- Undefined: no wr_flip port; wx always increments.

Test Plan:
1. Reset clear: assert rst 1 cycle, defaults (LINE_LEN=512) -> ready=0 for exactly 512 cycles then 1. First scan after line_start returns 512 pixels of 8'hFF with rd_valid, 1-cycle latency.
2. Basic line: wr_load wr_x=10, write 8'h21,8'h22,8'h23, then line_start and rd_en for 512 cycles. Pixels 10..12 read 21,22,23, all others FF; bank_sel toggles 0->1. A second scan of the same bank after the next line_start+1 reads all FF (clear-behind).
3. Priority/collision: object 1 at x=100 pix 8'h05; object 2 at x=100 pix 8'h07 -> read x=100 is 05, collision=1. Next line_start clears collision. Transparent pix 8'h0F over 05 -> 05 kept, no collision.
4. Wrap: wr_x=510, write 4 opaque pixels 31..34 -> locations 510,511,0,1 hold 31,32,33,34.
5. Simultaneous: line_start with wr_pix_valid=1 -> wr_drop pulses 1 cycle and nothing is stored. Also rst asserted mid-scan at rd_cnt=200 -> rd_valid=0 next cycle, ready=0, full clear pass rerun.
6. HFLIP (macro defined): wr_load wr_x=5 with wr_flip=1, write 41,42,43 -> locations 5,4,3 hold 41,42,43. wr_x=0 flipped with 2 pixels -> locations 0 and 511.

Source files
------------

// File: rtl/mo_line_buffer_pp.sv
// Ping-pong motion-object line buffer: the renderer fills one bank while the video path scans and clears the other.
// Optional horizontal flip of the write counter is enabled with `define MO_LINE_BUF_HFLIP_EN (adds input wr_flip).
module mo_line_buffer_pp #(
  parameter int LINE_LEN = 512,
  parameter int PIX_W    = 8,
  parameter int IDX_W    = 4,
  localparam int ADDR_W  = $clog2(LINE_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic              wr_pix_valid,
  input  logic [PIX_W-1:0]  wr_pix,
  input  logic              rd_en,
  output logic [PIX_W-1:0]  rd_pix,
  output logic              rd_valid,
  output logic              bank_sel,
  output logic              ready,
  output logic              collision,
  output logic              wr_drop
`ifdef MO_LINE_BUF_HFLIP_EN
  ,
  input  logic              wr_flip
`endif
);

  typedef enum logic [1:0] {INIT_CLR, IDLE, SCAN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [PIX_W-1:0]  FILL = '1;

  state_t state, state_nxt;

  logic [PIX_W-1:0]  bank_a [LINE_LEN];
  logic [PIX_W-1:0]  bank_b [LINE_LEN];
  logic [ADDR_W-1:0] clr_cnt, rd_cnt, wx, wr_addr, wx_step;
  logic [IDX_W-1:0]  loc_idx;
  logic              clr_both, active, scanning;
  logic              swap, do_read, wr_req, flip_eff;
  logic              pix_opaque, loc_opaque, store, hit;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_CLR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT_CLR: if (clr_cnt == LAST) state_nxt = IDLE;
      IDLE:     if (line_start) state_nxt = SCAN;
      SCAN:     if (!line_start && rd_en && rd_cnt == LAST) state_nxt = IDLE;
      default:  state_nxt = INIT_CLR;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    clr_both = 1'b0;
    active   = 1'b0;
    scanning = 1'b0;
    case (state)
      INIT_CLR: clr_both = 1'b1;
      IDLE: begin
        ready  = 1'b1;
        active = 1'b1;
      end
      SCAN: begin
        ready    = 1'b1;
        active   = 1'b1;
        scanning = 1'b1;
      end
      default: ;
    endcase
  end

  // A line_start cycle swaps banks only: any write is dropped and no read is issued.
  assign swap    = active & line_start;
  assign do_read = scanning & rd_en & ~line_start;
  assign wr_req  = active & wr_pix_valid & ~line_start;
  assign wr_addr = wr_load ? wr_x : wx;

  assign loc_idx    = bank_sel ? bank_b[wr_addr][IDX_W-1:0] : bank_a[wr_addr][IDX_W-1:0];
  assign pix_opaque = ~&wr_pix[IDX_W-1:0];
  assign loc_opaque = ~&loc_idx;
  assign store      = wr_req & pix_opaque & ~loc_opaque;
  assign hit        = wr_req & pix_opaque & loc_opaque;

`ifdef MO_LINE_BUF_HFLIP_EN
  logic flip_r;

  assign flip_eff = wr_load ? wr_flip : flip_r;

  always_ff @(posedge clk) begin
    if (rst)                    flip_r <= 1'b0;
    else if (active && wr_load) flip_r <= wr_flip;
  end
`else
  assign flip_eff = 1'b0;
`endif

  // Explicit wrap so LINE_LEN need not be a power of two.
  always_comb begin
    if (flip_eff) wx_step = (wr_addr == '0)   ? LAST : wr_addr - ONE;
    else          wx_step = (wr_addr == LAST) ? '0   : wr_addr + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pix    <= FILL;
      rd_valid  <= 1'b0;
      bank_sel  <= 1'b0;
      collision <= 1'b0;
      wr_drop   <= 1'b0;
      rd_cnt    <= '0;
      wx        <= '0;
      clr_cnt   <= '0;
    end else begin
      rd_valid <= do_read;
      wr_drop  <= swap & wr_pix_valid;
      if (clr_both) clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + ONE;
      if (do_read) rd_pix <= bank_sel ? bank_a[rd_cnt] : bank_b[rd_cnt];
      if (swap) begin
        bank_sel  <= ~bank_sel;
        rd_cnt    <= '0;
        collision <= 1'b0;
      end else begin
        if (do_read && rd_cnt != LAST) rd_cnt <= rd_cnt + ONE;
        if (hit) collision <= 1'b1;
      end
      if (wr_req)                 wx <= wx_step;
      else if (active && wr_load) wx <= wr_x;
    end
  end

  // Storage: clear pass writes both banks; otherwise the write bank stores and the read bank is cleared behind the scan.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_both) begin
        bank_a[clr_cnt] <= FILL;
        bank_b[clr_cnt] <= FILL;
      end else begin
        if (store) begin
          if (bank_sel) bank_b[wr_addr] <= wr_pix;
          else          bank_a[wr_addr] <= wr_pix;
        end
        if (do_read) begin
          if (bank_sel) bank_a[rd_cnt] <= FILL;
          else          bank_b[rd_cnt] <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_mo_line_buffer_pp.sv
// Self-checking bench for mo_line_buffer_pp: directed steps plus random traffic against a line-array reference model.
// Exercises the flip path as well when MO_LINE_BUF_HFLIP_EN is defined.
module tb_mo_line_buffer_pp;

  localparam int LL = 512;

  logic       clk = 1'b0;
  logic       rst, line_start, wr_load, wr_pix_valid, rd_en;
  logic [8:0] wr_x;
  logic [7:0] wr_pix, rd_pix;
  logic       rd_valid, bank_sel, ready, collision, wr_drop;
`ifdef MO_LINE_BUF_HFLIP_EN
  logic       wr_flip;
`endif

  mo_line_buffer_pp dut (
    .clk(clk), .rst(rst), .line_start(line_start), .wr_load(wr_load), .wr_x(wr_x),
    .wr_pix_valid(wr_pix_valid), .wr_pix(wr_pix), .rd_en(rd_en), .rd_pix(rd_pix),
    .rd_valid(rd_valid), .bank_sel(bank_sel), .ready(ready), .collision(collision),
    .wr_drop(wr_drop)
`ifdef MO_LINE_BUF_HFLIP_EN
    , .wr_flip(wr_flip)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: two line arrays indexed by bank number plus a few scalars.
  logic [7:0] m_mem [2][LL];
  int   m_init_left, m_rd, m_wx, m_bank;
  bit   m_ready, m_scan, m_coll, m_flip, m_valid, m_drop;
  logic [7:0] m_rd_pix;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic bit opaque(input logic [7:0] p);
    return p[3:0] != 4'hF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".ready"},     32'(ready),     32'(m_ready));
    check({ctx, ".rd_valid"},  32'(rd_valid),  32'(m_valid));
    check({ctx, ".wr_drop"},   32'(wr_drop),   32'(m_drop));
    check({ctx, ".bank_sel"},  32'(bank_sel),  32'(m_bank));
    check({ctx, ".collision"}, 32'(collision), 32'(m_coll));
    if (m_valid) check({ctx, ".rd_pix"}, 32'(rd_pix), 32'(m_rd_pix));
  endtask

  task automatic drive_idle_inputs();
    line_start = 1'b0; wr_load = 1'b0; wr_x = '0; wr_pix_valid = 1'b0; wr_pix = '0; rd_en = 1'b0;
`ifdef MO_LINE_BUF_HFLIP_EN
    wr_flip = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle_inputs();
    m_ready = 0; m_init_left = LL; m_scan = 0; m_bank = 0; m_coll = 0;
    m_flip = 0; m_rd = 0; m_wx = 0; m_rd_pix = 8'hFF; m_valid = 0; m_drop = 0;
    @(posedge clk); #1;
    check_all("reset");
    check("reset.rd_pix", 32'(rd_pix), 32'hFF);
    rst = 1'b0;
  endtask

  task automatic cycle(input bit ls, input bit ld, input int x, input bit pv,
                       input logic [7:0] pix, input bit re, input bit fl);
    int wb, rb;
    rst = 1'b0; line_start = ls; wr_load = ld; wr_x = 9'(x);
    wr_pix_valid = pv; wr_pix = pix; rd_en = re;
`ifdef MO_LINE_BUF_HFLIP_EN
    wr_flip = fl;
`endif
    m_valid = 0; m_drop = 0;
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_ready = 1;
        for (int i = 0; i < LL; i++) begin
          m_mem[0][i] = 8'hFF;
          m_mem[1][i] = 8'hFF;
        end
      end
    end else if (ls) begin
      m_drop = pv;
      m_bank = 1 - m_bank;
      m_rd = 0; m_coll = 0; m_scan = 1;
      if (ld) begin m_wx = x; m_flip = fl; end
    end else begin
      wb = m_bank;
      rb = 1 - m_bank;
      if (m_scan && re) begin
        m_valid = 1;
        m_rd_pix = m_mem[rb][m_rd];
        m_mem[rb][m_rd] = 8'hFF;
        if (m_rd == LL - 1) m_scan = 0;
        else m_rd++;
      end
      if (ld) begin m_wx = x; m_flip = fl; end
      if (pv) begin
        if (opaque(pix)) begin
          if (opaque(m_mem[wb][m_wx])) m_coll = 1;
          else m_mem[wb][m_wx] = pix;
        end
        m_wx = m_flip ? (m_wx + LL - 1) % LL : (m_wx + 1) % LL;
      end
    end
    @(posedge clk); #1;
    check_all("cycle");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic wr(input bit ld, input int x, input logic [7:0] pix, input bit fl);
    cycle(0, ld, x, 1, pix, 0, fl);
  endtask

  // Swap, read a whole line, then one extra rd_en that must not re-read.
  task automatic scan_line();
    cycle(1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < LL; i++) cycle(0, 0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 0, 0, 8'h00, 1, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ls, ld, pv, re, fl;
    int x;
    logic [7:0] pix;

    do_reset();
    idle(LL);
    check("ready_after_clear", 32'(ready), 32'h1);
    scan_line();

    wr(1, 10, 8'h21, 0);
    wr(0, 0, 8'h22, 0);
    wr(0, 0, 8'h23, 0);
    scan_line();
    scan_line();
    scan_line();

    wr(1, 100, 8'h05, 0);
    wr(1, 100, 8'h07, 0);
    check("collision_set", 32'(collision), 32'h1);
    scan_line();
    wr(1, 100, 8'h05, 0);
    wr(1, 100, 8'h0F, 0);
    check("no_collision_transparent", 32'(collision), 32'h0);
    scan_line();

    wr(1, 510, 8'h31, 0);
    wr(0, 0, 8'h32, 0);
    wr(0, 0, 8'h33, 0);
    wr(0, 0, 8'h34, 0);
    scan_line();

    cycle(1, 1, 50, 1, 8'h66, 0, 0);
    check("drop_pulse", 32'(wr_drop), 32'h1);
    wr(0, 0, 8'h44, 0);
    check("drop_one_cycle", 32'(wr_drop), 32'h0);
    scan_line();

`ifdef MO_LINE_BUF_HFLIP_EN
    wr(1, 5, 8'h41, 1);
    wr(0, 0, 8'h42, 1);
    wr(0, 0, 8'h43, 1);
    wr(1, 0, 8'h51, 1);
    wr(0, 0, 8'h52, 1);
    wr(1, 200, 8'h61, 0);
    wr(0, 0, 8'h62, 0);
    scan_line();
`endif

    for (int line = 0; line < 4; line++) begin
      cycle(1, 0, 0, 0, 8'h00, 0, 0);
      for (int c = 0; c < 700; c++) begin
        ld  = ($urandom_range(0, 9) == 0);
        x   = int'($urandom_range(0, LL - 1));
        pv  = ($urandom_range(0, 2) != 0);
        pix = 8'($urandom);
        re  = ($urandom_range(0, 1) == 1);
        ls  = ($urandom_range(0, 299) == 0);
        fl  = 0;
`ifdef MO_LINE_BUF_HFLIP_EN
        fl  = ($urandom_range(0, 1) == 1);
`endif
        cycle(ls, ld, x, pv, pix, re, fl);
      end
    end

    wr(1, 300, 8'h12, 0);
    cycle(1, 0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 200; i++) cycle(0, 0, 0, 0, 8'h00, 1, 0);
    do_reset();
    check("midscan_reset.rd_valid", 32'(rd_valid), 32'h0);
    check("midscan_reset.ready", 32'(ready), 32'h0);
    idle(LL);
    scan_line();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
